mem_arbiter: RTL

- Shares the single line-wide main memory port between the I-cache (read-only) and the D-cache (read and write-back).
- Latches one requester's transaction, then sequences the memory's handshake, which has three rules:
  - the address must be stable for one cycle before the request;
  - the request is held until memory gnt;
  - the request is dropped for at least one cycle afterwards, so the memory's delay counters clear.
- Sits between both cache controllers and the memory instance in the top level.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 34 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizes for the main-memory port arbiter
package mem_arb_pkg;

  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int LINE_SIZE         = 1 << LINE_ADDR_LEN_DEF;

  typedef enum logic [1:0] {IDLE, SETUP, BUSY, DONE} state_t;
  typedef enum logic       {OP_RD, OP_WR}            op_t;
  typedef enum logic       {OWN_DC, OWN_IC}          owner_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker; bit 0 is the D-cache, bit 1 the I-cache
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  owner_t r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_ptr == OWN_IC) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // The pointer always moves to the requester that did not just win.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= OWN_DC;
    end else if (i_advance) begin
      if (o_grant[0])      r_ptr <= OWN_IC;
      else if (o_grant[1]) r_ptr <= OWN_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the line-wide memory port between I-cache and D-cache
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter  int ADDR_LEN      = 8,
  parameter  int TIMEOUT       = 64,
  localparam int LINE_W        = 32 * (1 << LINE_ADDR_LEN)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ic_rd_req,
  input  logic [ADDR_LEN-1:0] i_ic_addr,
  output logic                o_ic_gnt,
  input  logic                i_dc_rd_req,
  input  logic                i_dc_wr_req,
  input  logic [ADDR_LEN-1:0] i_dc_addr,
  input  logic [LINE_W-1:0]   i_dc_wr_line,
  output logic                o_dc_gnt,
  output logic [LINE_W-1:0]   o_rd_line,
  output logic [ADDR_LEN-1:0] o_mem_addr,
  output logic                o_mem_rd_req,
  output logic                o_mem_wr_req,
  output logic [LINE_W-1:0]   o_mem_wr_line,
  input  logic                i_mem_gnt,
  input  logic [LINE_W-1:0]   i_mem_rd_line,
  output logic                o_timeout_err
);

  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  op_t                 r_op;
  owner_t              r_owner;
  logic [ADDR_LEN-1:0] r_addr;
  logic [LINE_W-1:0]   r_line;
  logic                r_mem_rd_req, r_mem_wr_req;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_timeout_err;
  logic [1:0]          w_req, w_grant;
  logic                w_win;

  assign w_req = {i_ic_rd_req, i_dc_rd_req | i_dc_wr_req};
  assign w_win = (r_state == IDLE) && (w_req != 2'b00);

  rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (w_req),
    .i_advance (w_win),
    .o_grant   (w_grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = BUSY;
      BUSY:    if (i_mem_gnt) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ic_gnt = (r_state == DONE) && (r_owner == OWN_IC);
    o_dc_gnt = (r_state == DONE) && (r_owner == OWN_DC);
  end

  // Requests are registered from the next state so they rise on BUSY entry and fall right after gnt.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op          <= OP_RD;
      r_owner       <= OWN_DC;
      r_addr        <= '0;
      r_line        <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_wr_req  <= 1'b0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_win) begin
        r_line <= i_dc_wr_line;
        if (w_grant[1]) begin
          r_owner <= OWN_IC;
          r_op    <= OP_RD;
          r_addr  <= i_ic_addr;
        end else if (w_grant[0]) begin
          r_owner <= OWN_DC;
          r_op    <= i_dc_rd_req ? OP_RD : OP_WR;
          r_addr  <= i_dc_addr;
        end
      end
      r_mem_rd_req <= (w_state_nxt == BUSY) && (r_op == OP_RD);
      r_mem_wr_req <= (w_state_nxt == BUSY) && (r_op == OP_WR);
      if (r_state == BUSY) begin
        if (r_wait_cnt != CNT_TO) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == CNT_TO_M1) r_timeout_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_mem_addr    = r_addr;
  assign o_mem_rd_req  = r_mem_rd_req;
  assign o_mem_wr_req  = r_mem_wr_req;
  assign o_mem_wr_line = r_line;
  assign o_rd_line     = i_mem_rd_line;
  assign o_timeout_err = r_timeout_err;

endmodule
